// File: rtl/ac97_pkg.sv
// AC'97 frame layout constants and the command record shared by the
// frame transmitter and its command buffer.
package ac97_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int TAG_BITS    = 16;
    localparam int SLOT_BITS   = 20;

    localparam int SLOT1_START = 16;
    localparam int SLOT2_START = 36;
    localparam int SLOT3_START = 56;
    localparam int SLOT4_START = 76;
    localparam int SLOT5_START = 96;

    localparam int TAG_VALID    = 15;
    localparam int TAG_CMD_ADDR = 14;
    localparam int TAG_CMD_DATA = 13;
    localparam int TAG_PCM_L    = 12;
    localparam int TAG_PCM_R    = 11;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } ac97_cmd_t;

endpackage

// File: rtl/ac97_cmd_buffer.sv
// One-entry codec register write buffer with valid/ready handshake.
// Ports: i_clk, i_rst (sync, active high), i_live (out of reset),
//   i_valid/i_addr/i_data request, i_pop (frame snapshot),
//   o_ready (buffer empty), o_valid/o_cmd (held entry).
module ac97_cmd_buffer
    import ac97_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_live,
    input  logic        i_valid,
    input  logic [6:0]  i_addr,
    input  logic [15:0] i_data,
    input  logic        i_pop,
    output logic        o_ready,
    output logic        o_valid,
    output ac97_cmd_t   o_cmd
);

    logic      r_valid;
    ac97_cmd_t r_cmd;
    logic      w_acc;

    // Ready stays low in the reset cycle itself.
    assign o_ready = i_live & ~r_valid;
    assign w_acc   = i_valid & o_ready;
    assign o_valid = r_valid;
    assign o_cmd   = r_cmd;

    // An accept coinciding with a pop wins: the pop took the old
    // (empty) contents, the new entry waits for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_cmd   <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_cmd   <= '{addr: i_addr, data: i_data};
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ac97_frame_transmitter.sv
// AC'97 SDATA_OUT/SYNC frame serializer: tag, command slots 1/2, PCM 3/4.
// Ports: I_BITCLK, I_RESET (sync, active high), I_LEFT/RIGHT_SAMPLE,
//   I_PCM_EN, I_CMD_VALID/ADDR/DATA, O_CMD_READY, O_STROBE, O_SYNC, O_SDATA.
// Macro AC97_CMD_EN enables the command buffer and slots 1/2.
module ac97_frame_transmitter
    import ac97_pkg::*;
(
    input  logic        I_BITCLK,
    input  logic        I_RESET,
    input  logic [19:0] I_LEFT_SAMPLE,
    input  logic [19:0] I_RIGHT_SAMPLE,
    input  logic        I_PCM_EN,
    input  logic        I_CMD_VALID,
    input  logic [6:0]  I_CMD_ADDR,
    input  logic [15:0] I_CMD_DATA,
    output logic        O_CMD_READY,
    output logic        O_STROBE,
    output logic        O_SYNC,
    output logic        O_SDATA
);

    // r_cnt is the index of the bit driven at the next edge,
    // so during V(k) it holds k+1.
    logic [7:0]  r_cnt;
    logic        r_run;
    logic        r_pcm;
    logic        r_cmd_vld;
    ac97_cmd_t   r_cmd;
    logic [19:0] r_left;
    logic [19:0] r_right;
    logic        r_sync;
    logic        r_sdata;
    logic        r_strobe;

    logic        w_snap;
    logic        w_cap;
    logic        w_buf_valid;
    ac97_cmd_t   w_buf_cmd;
    logic [15:0] w_tag;
    logic [19:0] w_slot;
    logic [4:0]  w_pos;
    logic        w_bit;

    // r_cnt==0 with r_run set is the edge that ends V(255).
    assign w_snap = r_run & (r_cnt == 8'd0);
    assign w_cap  = (r_cnt == 8'd1);

`ifdef AC97_CMD_EN
    ac97_cmd_buffer u_cmd (
        .i_clk   (I_BITCLK),
        .i_rst   (I_RESET),
        .i_live  (r_run),
        .i_valid (I_CMD_VALID),
        .i_addr  (I_CMD_ADDR),
        .i_data  (I_CMD_DATA),
        .i_pop   (w_snap),
        .o_ready (O_CMD_READY),
        .o_valid (w_buf_valid),
        .o_cmd   (w_buf_cmd)
    );
`else
    logic w_unused_cmd;
    assign w_unused_cmd = ^{I_CMD_VALID, I_CMD_ADDR, I_CMD_DATA};
    assign O_CMD_READY  = 1'b0;
    assign w_buf_valid  = 1'b0;
    assign w_buf_cmd    = '0;
`endif

    always_comb begin
        w_tag               = '0;
        w_tag[TAG_VALID]    = 1'b1;
        w_tag[TAG_CMD_ADDR] = r_cmd_vld;
        w_tag[TAG_CMD_DATA] = r_cmd_vld;
        w_tag[TAG_PCM_L]    = r_pcm;
        w_tag[TAG_PCM_R]    = r_pcm;
    end

    always_comb begin
        w_slot = '0;
        w_pos  = '0;
        w_bit  = 1'b0;
        if (r_cnt < 8'(SLOT1_START)) begin
            w_bit = w_tag[4'(TAG_BITS - 1) - r_cnt[3:0]];
        end else begin
            if (r_cnt < 8'(SLOT2_START)) begin
                if (r_cmd_vld)
                    w_slot = {1'b0, r_cmd.addr, 12'h000};
                w_pos = 5'(r_cnt - 8'(SLOT1_START));
            end else if (r_cnt < 8'(SLOT3_START)) begin
                if (r_cmd_vld)
                    w_slot = {r_cmd.data, 4'h0};
                w_pos = 5'(r_cnt - 8'(SLOT2_START));
            end else if (r_cnt < 8'(SLOT4_START)) begin
                if (r_pcm)
                    w_slot = r_left;
                w_pos = 5'(r_cnt - 8'(SLOT3_START));
            end else if (r_cnt < 8'(SLOT5_START)) begin
                if (r_pcm)
                    w_slot = r_right;
                w_pos = 5'(r_cnt - 8'(SLOT4_START));
            end
            w_bit = w_slot[5'(SLOT_BITS - 1) - w_pos];
        end
    end

    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_pcm     <= 1'b0;
            r_cmd_vld <= 1'b0;
            r_cmd     <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_sync    <= 1'b0;
            r_sdata   <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
            r_sync   <= (r_cnt < 8'(TAG_BITS));
            r_sdata  <= w_bit;
            r_strobe <= (r_cnt == 8'(FRAME_BITS - 1));
            if (w_snap) begin
                r_pcm     <= I_PCM_EN;
                r_cmd_vld <= w_buf_valid;
                r_cmd     <= w_buf_cmd;
            end
            if (w_cap) begin
                r_left  <= I_LEFT_SAMPLE;
                r_right <= I_RIGHT_SAMPLE;
            end
        end
    end

    assign O_SYNC   = r_sync;
    assign O_SDATA  = r_sdata;
    assign O_STROBE = r_strobe;

endmodule

// File: tb/tb_ac97_frame_transmitter.sv
// Randomized bench for ac97_frame_transmitter against a frame-level model.
// Honours AC97_CMD_EN the same way the design does.
module tb_ac97_frame_transmitter;

    logic        clk = 1'b0;
    logic        I_RESET;
    logic [19:0] I_LEFT_SAMPLE;
    logic [19:0] I_RIGHT_SAMPLE;
    logic        I_PCM_EN;
    logic        I_CMD_VALID;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY;
    logic        O_STROBE;
    logic        O_SYNC;
    logic        O_SDATA;

    always #5 clk = ~clk;

    ac97_frame_transmitter dut (
        .I_BITCLK       (clk),
        .I_RESET        (I_RESET),
        .I_LEFT_SAMPLE  (I_LEFT_SAMPLE),
        .I_RIGHT_SAMPLE (I_RIGHT_SAMPLE),
        .I_PCM_EN       (I_PCM_EN),
        .I_CMD_VALID    (I_CMD_VALID),
        .I_CMD_ADDR     (I_CMD_ADDR),
        .I_CMD_DATA     (I_CMD_DATA),
        .O_CMD_READY    (O_CMD_READY),
        .O_STROBE       (O_STROBE),
        .O_SYNC         (O_SYNC),
        .O_SDATA        (O_SDATA)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int          sc;
    int          k;
    bit          in_rst;
    bit          m_pend;
    logic [6:0]  m_addr;
    logic [15:0] m_data;
    bit          s_pcm;
    bit          s_cmd;
    logic [6:0]  s_addr;
    logic [15:0] s_data;
    logic [19:0] cap_l;
    logic [19:0] cap_r;
    logic [19:0] e_word [5];
    bit          frame [256];
    bit          obs   [256];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic bit exp_ready();
`ifdef AC97_CMD_EN
        return !m_pend;
`else
        return 1'b0;
`endif
    endfunction

    // word 0 = tag, words 1..4 = slots; slot n starts at 16+20(n-1)
    task automatic build_frame();
        e_word[0] = 20'h08000;
        if (s_cmd) e_word[0] = e_word[0] | 20'h06000;
        if (s_pcm) e_word[0] = e_word[0] | 20'h01800;
        e_word[1] = s_cmd ? {1'b0, s_addr, 12'h000} : 20'h0;
        e_word[2] = s_cmd ? {s_data, 4'h0} : 20'h0;
        e_word[3] = s_pcm ? cap_l : 20'h0;
        e_word[4] = s_pcm ? cap_r : 20'h0;
        for (int i = 0; i < 256; i++) frame[i] = 1'b0;
        for (int i = 0; i < 16; i++) frame[i] = e_word[0][15 - i];
        for (int n = 1; n <= 4; n++)
            for (int i = 0; i < 20; i++)
                frame[16 + 20 * (n - 1) + i] = e_word[n][19 - i];
    endtask

    task automatic frame_checks();
        logic [19:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w = {w[18:0], obs[i]};
        check("tag", w, e_word[0]);
        for (int n = 1; n <= 4; n++) begin
            w = '0;
            for (int i = 0; i < 20; i++)
                w = {w[18:0], obs[16 + 20 * (n - 1) + i]};
            check($sformatf("slot%0d", n), w, e_word[n]);
        end
    endtask

    task automatic model_clear();
        m_pend = 0; m_addr = '0; m_data = '0;
        s_pcm = 0; s_cmd = 0; s_addr = '0; s_data = '0;
        cap_l = '0; cap_r = '0;
    endtask

    task automatic drive();
        I_RESET        = 1'b0;
        I_CMD_VALID    = 1'b0;
        I_CMD_ADDR     = 7'($urandom);
        I_CMD_DATA     = 16'($urandom);
        I_LEFT_SAMPLE  = 20'($urandom);
        I_RIGHT_SAMPLE = 20'($urandom);
        I_PCM_EN       = 1'b0;
        case (sc)
            0: I_RESET = 1'b1;
            2: begin
                I_PCM_EN = 1'b1;
                if (k == 0) begin
                    I_LEFT_SAMPLE  = 20'h7FFFF;
                    I_RIGHT_SAMPLE = 20'h80001;
                end
            end
            3: begin
                I_PCM_EN    = 1'($urandom);
                I_CMD_VALID = (k == 100);
                I_CMD_ADDR  = 7'h02;
                I_CMD_DATA  = 16'h0808;
            end
            4: I_CMD_VALID = (k == 255);
            5: begin
                I_PCM_EN    = 1'($urandom);
                I_CMD_VALID = ($urandom_range(0, 15) == 0);
            end
            6: begin
                I_CMD_VALID = (k == 50);
                I_RESET     = (k == 100);
            end
            default: ;
        endcase
    endtask

    task automatic step();
        bit acc;
        @(posedge clk);
        #1;
        if (in_rst) begin
            check("rst_sync",   O_SYNC,      0);
            check("rst_sdata",  O_SDATA,     0);
            check("rst_strobe", O_STROBE,    0);
            check("rst_ready",  O_CMD_READY, 0);
        end else begin
            check("sync",   O_SYNC,      k < 16);
            check("strobe", O_STROBE,    k == 255);
            check("ready",  O_CMD_READY, exp_ready());
            check("sdata",  O_SDATA,     (k == 0) ? 1'b1 : frame[k]);
            obs[k] = O_SDATA;
            if (k == 255) frame_checks();
        end
        drive();
        if (I_RESET) begin
            in_rst = 1;
            model_clear();
            k = 0;
        end else if (in_rst) begin
            in_rst = 0;
            k = 0;
        end else begin
            acc = I_CMD_VALID && exp_ready();
            if (k == 0) begin
                cap_l = I_LEFT_SAMPLE;
                cap_r = I_RIGHT_SAMPLE;
                build_frame();
            end
            if (k == 255) begin
                s_pcm  = I_PCM_EN;
                s_cmd  = m_pend;
                s_addr = m_addr;
                s_data = m_data;
                m_pend = 0;
            end
            if (acc) begin
                m_pend = 1;
                m_addr = I_CMD_ADDR;
                m_data = I_CMD_DATA;
            end
            k = (k + 1) % 256;
        end
    endtask

    task automatic do_reset(int n);
        sc = 0;
        repeat (n) step();
        sc = 1;
        step();
    endtask

    task automatic run_frames(int s, int n);
        sc = s;
        repeat (256 * n) step();
    endtask

    initial begin
        I_RESET        = 1'b1;
        I_LEFT_SAMPLE  = '0;
        I_RIGHT_SAMPLE = '0;
        I_PCM_EN       = 1'b0;
        I_CMD_VALID    = 1'b0;
        I_CMD_ADDR     = '0;
        I_CMD_DATA     = '0;
        in_rst = 1;
        k = 0;
        model_clear();
        build_frame();
        @(posedge clk);
        do_reset(3);
        run_frames(1, 2);
        run_frames(2, 3);
        run_frames(3, 2);
        run_frames(4, 3);
        run_frames(5, 6);
        run_frames(1, 1);
        sc = 6;
        repeat (101) step();
        do_reset(1);
        run_frames(1, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
